// File: rtl/psu_cwd_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psu_cwd_sched_pkg : shared constants, state type and helpers for the     |
// | PSU codeword issue scheduler.                          Rev 1.0           |
// +--------------------------------------------------------------------------+
package psu_cwd_sched_pkg;

  // Address width for n items, never below 1 bit.
  function automatic int addr_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (base + off) mod n for 0 <= base, off < n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

  localparam int c_CWD_I        = 4;
  localparam int c_PSU_LOCK_CYC = 3;
  localparam int c_PSU_NUM_PCH  = 4;
  localparam int c_PCHADDR_BW   = addr_bw(c_PSU_NUM_PCH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage
`default_nettype wire

// File: rtl/psu_pch_lock.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psu_pch_lock : per-patch lock window counter.          Rev 1.0           |
// +--------------------------------------------------------------------------+
module psu_pch_lock
  import psu_cwd_sched_pkg::*;
#(
  parameter int LOCK_CYC = c_PSU_LOCK_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_locked
);

  localparam int c_CNT_BW = addr_bw(LOCK_CYC + 1);

  logic [c_CNT_BW-1:0] r_cnt;

  // Loading LOCK_CYC=0 leaves the counter at zero, so locking is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_CNT_BW'(LOCK_CYC);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_locked = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/psu_cwd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | psu_cwd_sched : round-robin codeword arbiter that merges compatible      |
// | PCU requests into one patch-expanded issue bundle.     Rev 1.0           |
// +--------------------------------------------------------------------------+
module psu_cwd_sched
  import psu_cwd_sched_pkg::*;
#(
  parameter int NUM_PCU    = 4,
  parameter int NUM_PCH    = c_PSU_NUM_PCH,
  parameter int PQ_PER_PCH = 16,
  parameter int CWD_BW     = c_CWD_I,
  parameter int LOCK_CYC   = c_PSU_LOCK_CYC
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PCU-1:0]                  i_req_valid,
  input  logic [NUM_PCU*addr_bw(NUM_PCH)-1:0] i_req_pch,
  input  logic [NUM_PCU*PQ_PER_PCH-1:0]       i_req_mask,
  input  logic [NUM_PCU*PQ_PER_PCH-1:0]       i_req_special,
  input  logic [NUM_PCU*CWD_BW-1:0]           i_req_cwd,
  input  logic [NUM_PCU*CWD_BW-1:0]           i_req_cwdsp,
  output logic [NUM_PCU-1:0]                  o_req_grant,
  output logic                                o_out_valid,
  input  logic                                i_out_ready,
  output logic [NUM_PCH*PQ_PER_PCH-1:0]       o_mask_ext_array,
  output logic [NUM_PCH*PQ_PER_PCH-1:0]       o_special_ext_array,
  output logic [CWD_BW-1:0]                   o_cwd,
  output logic [CWD_BW-1:0]                   o_cwdsp,
  output logic [NUM_PCH-1:0]                  o_pch_locked
);

  localparam int c_PCH_BW = addr_bw(NUM_PCH);
  localparam int c_PCU_BW = addr_bw(NUM_PCU);
  localparam int c_NUM_PQ = NUM_PCH * PQ_PER_PCH;

  logic [c_PCH_BW-1:0]   w_pch     [NUM_PCU];
  logic [PQ_PER_PCH-1:0] w_mask    [NUM_PCU];
  logic [PQ_PER_PCH-1:0] w_special [NUM_PCU];
  logic [CWD_BW-1:0]     w_cwd     [NUM_PCU];
  logic [CWD_BW-1:0]     w_cwdsp   [NUM_PCU];
  logic [NUM_PCU-1:0]    w_elig;
  logic                  w_slot_free;

  logic [c_PCU_BW-1:0]   r_rr_ptr;
  logic [c_PCU_BW-1:0]   w_leader;
  logic [c_PCU_BW-1:0]   w_idx;
  logic [c_PCU_BW-1:0]   w_rr_nxt;
  logic                  w_any;
  logic [NUM_PCU-1:0]    w_grant;
  logic [NUM_PCH-1:0]    w_used;
  logic [NUM_PCH-1:0]    w_lock_load;
  logic [c_NUM_PQ-1:0]   w_mask_nxt;
  logic [c_NUM_PQ-1:0]   w_spec_nxt;

  out_state_e            r_state;
  out_state_e            w_state_nxt;

  assign w_slot_free = (r_state == ST_EMPTY) | i_out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PCU; gi++) begin : g_unpack
      assign w_pch[gi]     = i_req_pch[gi*c_PCH_BW +: c_PCH_BW];
      assign w_mask[gi]    = i_req_mask[gi*PQ_PER_PCH +: PQ_PER_PCH];
      assign w_special[gi] = i_req_special[gi*PQ_PER_PCH +: PQ_PER_PCH];
      assign w_cwd[gi]     = i_req_cwd[gi*CWD_BW +: CWD_BW];
      assign w_cwdsp[gi]   = i_req_cwdsp[gi*CWD_BW +: CWD_BW];
      assign w_elig[gi]    = i_req_valid[gi] & ~o_pch_locked[w_pch[gi]] & w_slot_free & ~rst;
    end
  endgenerate

  // Leader is the first eligible requester from r_rr_ptr; followers must share
  // the leader's codeword pair and claim a patch nobody else in the bundle has.
  always_comb begin
    w_grant  = '0;
    w_any    = 1'b0;
    w_leader = '0;
    w_idx    = '0;
    w_used   = '0;
    for (int k = 0; k < NUM_PCU; k++) begin
      w_idx = c_PCU_BW'(wrap_add(int'(r_rr_ptr), k, NUM_PCU));
      if (!w_any && w_elig[w_idx]) begin
        w_any    = 1'b1;
        w_leader = w_idx;
      end
    end
    if (w_any) begin
      w_grant[w_leader]       = 1'b1;
      w_used[w_pch[w_leader]] = 1'b1;
      for (int k = 1; k < NUM_PCU; k++) begin
        w_idx = c_PCU_BW'(wrap_add(int'(w_leader), k, NUM_PCU));
        if (w_elig[w_idx] && (w_cwd[w_idx] == w_cwd[w_leader]) &&
            (w_cwdsp[w_idx] == w_cwdsp[w_leader]) && !w_used[w_pch[w_idx]]) begin
          w_grant[w_idx]       = 1'b1;
          w_used[w_pch[w_idx]] = 1'b1;
        end
      end
    end
  end

  assign w_rr_nxt    = c_PCU_BW'(wrap_add(int'(w_leader), 1, NUM_PCU));
  assign o_req_grant = w_grant;

  always_comb begin
    w_mask_nxt  = '0;
    w_spec_nxt  = '0;
    w_lock_load = '0;
    for (int i = 0; i < NUM_PCU; i++) begin
      if (w_grant[i]) begin
        w_mask_nxt[int'(w_pch[i])*PQ_PER_PCH +: PQ_PER_PCH] = w_mask[i];
        w_spec_nxt[int'(w_pch[i])*PQ_PER_PCH +: PQ_PER_PCH] = w_special[i];
        w_lock_load[w_pch[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants only happen when the slot is free, so FULL with !ready simply holds.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_any) w_state_nxt = ST_FULL;
      ST_FULL:  if (i_out_ready && !w_any) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  assign o_out_valid = (r_state == ST_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mask_ext_array    <= '0;
      o_special_ext_array <= '0;
      o_cwd               <= '0;
      o_cwdsp             <= '0;
      r_rr_ptr            <= '0;
    end else if (w_any) begin
      o_mask_ext_array    <= w_mask_nxt;
      o_special_ext_array <= w_spec_nxt;
      o_cwd               <= w_cwd[w_leader];
      o_cwdsp             <= w_cwdsp[w_leader];
      r_rr_ptr            <= w_rr_nxt;
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PCH; gp++) begin : g_lock
      psu_pch_lock #(
        .LOCK_CYC (LOCK_CYC)
      ) u_lock (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_lock_load[gp]),
        .o_locked (o_pch_locked[gp])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/psu_cwd_sched.md
# psu_cwd_sched

Codeword issue scheduler for the pulse-steering unit (PSU). It arbitrates codeword requests from `NUM_PCU` patch control units and merges compatible requests into one issue bundle per cycle. Each bundle is a patch-expanded mask array, a special array, and one `cwd`/`cwdsp` pair, and it drives `psu_cwdarrgen` directly. The scheduler also enforces a per-patch lock window so a patch cannot receive a new codeword while its previous gate is still playing.

## Interface
Parameters:
- `NUM_PCU`, 4: number of requesters.
- `NUM_PCH`, 4: number of patches; power of two.
- `PQ_PER_PCH`, 16: physical qubits per patch. Derived: `NUM_PQ = NUM_PCH*PQ_PER_PCH`.
- `CWD_BW`, 4: codeword width.
- `LOCK_CYC`, 3: cycles a patch stays locked after a grant. 0 disables locking.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  `NUM_PCU`: per-requester request.
- `req_pch`  in  `NUM_PCU*clog2(NUM_PCH)`: target patch.
- `req_mask`  in  `NUM_PCU*PQ_PER_PCH`: qubits driven within the patch.
- `req_special`  in  `NUM_PCU*PQ_PER_PCH`: qubits that take `cwdsp`.
- `req_cwd`, `req_cwdsp`  in  `NUM_PCU*CWD_BW`: codeword pair.
- `req_grant`  out  `NUM_PCU`: combinational; a request is consumed when `req_valid & req_grant`.
- `out_valid`  out  1: bundle valid.
- `out_ready`  in  1: downstream accepts the bundle.
- `mask_ext_array`, `special_ext_array`  out  `NUM_PQ`: expanded masks.
- `cwd`, `cwdsp`  out  `CWD_BW`: bundle codewords.
- `pch_locked`  out  `NUM_PCH`: lock status per patch.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i]` is high, `pch_locked[req_pch_i]` is low, and the issue slot is free. The slot is free when `!out_valid | out_ready`.
- **Leader.** The leader is the first eligible requester scanning round-robin from `rr_ptr`.
- **Followers.** Scan continues in round-robin order from leader+1. A follower merges only if all of the following hold:
  - it is eligible;
  - its `cwd` and `cwdsp` match the leader's bit for bit;
  - its patch differs from the leader's and from every follower already merged.
- **Deferred requests.** A non-merged eligible requester gets no grant and retries later. Its `req_*` inputs must stay stable until granted.
- **Grant.** `req_grant` is asserted for the leader and every merged follower.
- **Bundle load.** On a grant cycle the output registers load:
  - `mask_ext_array[p*PQ_PER_PCH +: PQ_PER_PCH] = req_mask` of the granted requester on patch p, else 0;
  - `special_ext_array` is built the same way from `req_special`;
  - `cwd`/`cwdsp` take the leader's pair;
  - `out_valid` is set to 1.
- **Pointer.** After a grant, `rr_ptr` advances to leader+1 mod `NUM_PCU`. It is unchanged when there is no grant.
- **Lock counters.** Each patch has a counter, loaded with `LOCK_CYC` when the patch is granted and decremented while non-zero. `pch_locked[p] = (cnt[p] != 0)`.
- **Output register states (2).**
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
  - EMPTY→FULL on grant.
  - FULL→FULL when `out_ready` is high and there is a grant (back-to-back).
  - FULL→EMPTY when `out_ready` is high and there is no grant.
  - FULL holds with bundle stable while `out_ready` is low.
- **Backpressure.** While `out_valid & !out_ready`, no grants are issued and lock counters still decrement.
- **Reset.** All of the following are 0: `out_valid`, both arrays, `cwd`, `cwdsp`, `rr_ptr`, all lock counters, `pch_locked`. `req_grant` is forced to 0 while `rst` is high. Reset mid-bundle discards it with no `out_valid` pulse.

## Timing
- Grant in cycle t; bundle visible with `out_valid` at t+1. Sustained throughput is one bundle per cycle.
- A patch granted at t is ineligible in cycles t+1..t+`LOCK_CYC` and eligible again at t+`LOCK_CYC`+1.
- `req_grant` depends combinationally on `req_*`, `out_ready` and state. There is no combinational path from `out_ready` to `out_valid`.
- Simultaneous unlock and request in the same cycle: the request is eligible once the counter reads 0 at the start of the cycle.

## Structure
- `define.v` additions: `CWD_I`, `PSU_LOCK_CYC`, `PCHADDR_BW` sized from `NUM_PCH`.
- Sub-module `psu_pch_lock`: one lock counter per instance, with load, decrement and `locked` output; instantiated `NUM_PCH` times.
- Arbitration, merge and expansion live in the top module.

## Test plan
- **Single request.** `rst` released; req0 pch=2, mask=16'h00F0, cwd=5, cwdsp=7. Expected: grant0 at t, `out_valid` at t+1, `mask_ext_array` bits 32..47 = 16'h00F0, all other bits 0, `cwd`=5. Patch 2 `pch_locked` high for 3 cycles.
- **Merge.** req0 pch0 and req1 pch1, same cwd=3/cwdsp=3, one cycle. Expected: both granted in the same cycle, one bundle with both patch slices set.
- **Codeword conflict.** req0 cwd=1, req1 cwd=2, distinct patches, `rr_ptr`=0. Expected: req0 granted first, req1 the next cycle, `rr_ptr` = 2 afterwards.
- **Patch and lock conflict.** req0 and req1 both target pch3. Expected: req0 granted, req1 waits for the lock and is granted 4 cycles later.
- **Backpressure.** `out_ready` held low 5 cycles with requests pending. Expected: bundle stable, no grants; resumes on the `out_ready` cycle.
- **Reset mid-stream.** `rst` asserted while `out_valid`=1 and locks active. Expected: next cycle all outputs 0, `req_grant` 0.
